// File: rtl/tick_pkg.sv
// Shared constants, helpers and divisor checks for the stopwatch timebase.
// Imported by div_tick and tick_gen.
package tick_pkg;

  localparam int unsigned CLK_HZ_DEF = 100_000_000;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

`define TICK_DIVCHK(n, d) \
  if (((n) % (d)) != 0) begin \
    $error("tick_gen: %0d not divisible by %0d", (n), (d)); \
  end

// File: rtl/div_tick.sv
// Single divider channel: counts 0..DIV-1, emits a one-cycle enable
// and a registered square wave.
module div_tick
  import tick_pkg::*;
#(
  parameter int unsigned DIV  = 4,
  parameter bit          HALF = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic clr,
  output logic en,
  output logic sq,
  output logic pre
);

  localparam int unsigned W = clog2_min1(DIV);

  logic [W-1:0] cnt;
  logic         term;
  logic         mid;

  assign term = (cnt == W'(DIV - 1));
  assign mid  = HALF && (cnt == W'(DIV / 2 - 1));
  // Next-cycle enable, exposed so the parent can register companions in step
  assign pre  = ce && !clr && term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      en  <= 1'b0;
      sq  <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      en  <= 1'b0;
      sq  <= 1'b0;
    end else begin
      en <= pre;
      if (ce) begin
        cnt <= term ? '0 : cnt + 1'b1;
        if (term || mid)
          sq <= ~sq;
      end
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Stopwatch timebase: free-running scan/blink enables plus a pausable,
// clearable 2 Hz / 1 Hz / minute chain.
module tick_gen
  import tick_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_DEF,
  parameter int unsigned FAST_HZ     = 500,
  parameter int unsigned BLINK_HZ    = 4,
  parameter int unsigned SEC_PER_MIN = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic en_fast,
  output logic en_blink,
  output logic en_2hz,
  output logic en_1hz,
  output logic en_1min,
  output logic sq_fast,
  output logic sq_blink,
  output logic sq_2hz,
  output logic sq_1hz,
  output logic [$clog2(SEC_PER_MIN)-1:0] sec_cnt
);

  localparam int unsigned FAST_DIV  = CLK_HZ / FAST_HZ;
  localparam int unsigned BLINK_DIV = CLK_HZ / BLINK_HZ;
  localparam int unsigned HS_DIV    = CLK_HZ / 2;
  localparam int unsigned SW        = $clog2(SEC_PER_MIN);

  `TICK_DIVCHK(CLK_HZ, 2)
  `TICK_DIVCHK(CLK_HZ, 2 * FAST_HZ)
  `TICK_DIVCHK(CLK_HZ, 2 * BLINK_HZ)

  if (SEC_PER_MIN < 2) begin : g_bad_spm
    $error("tick_gen: SEC_PER_MIN must be at least 2");
  end

  logic fast_pre_unused;
  logic blink_pre_unused;
  logic hs_pre;
  logic sec_step;

  div_tick #(.DIV(FAST_DIV), .HALF(1'b1)) u_fast (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (1'b1),
    .clr   (1'b0),
    .en    (en_fast),
    .sq    (sq_fast),
    .pre   (fast_pre_unused)
  );

  div_tick #(.DIV(BLINK_DIV), .HALF(1'b1)) u_blink (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (1'b1),
    .clr   (1'b0),
    .en    (en_blink),
    .sq    (sq_blink),
    .pre   (blink_pre_unused)
  );

  // Square toggles only on en_2hz, so it doubles as the phase flag
  div_tick #(.DIV(HS_DIV), .HALF(1'b0)) u_hs (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (run),
    .clr   (clear),
    .en    (en_2hz),
    .sq    (sq_2hz),
    .pre   (hs_pre)
  );

  assign sec_step = hs_pre && sq_2hz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_1hz  <= 1'b0;
      en_1min <= 1'b0;
      sq_1hz  <= 1'b0;
      sec_cnt <= '0;
    end else if (clear) begin
      en_1hz  <= 1'b0;
      en_1min <= 1'b0;
      sq_1hz  <= 1'b0;
      sec_cnt <= '0;
    end else begin
      en_1hz  <= sec_step;
      en_1min <= sec_step && (sec_cnt == SW'(SEC_PER_MIN - 1));
      if (sec_step) begin
        sq_1hz  <= ~sq_1hz;
        sec_cnt <= (sec_cnt == SW'(SEC_PER_MIN - 1))
                   ? '0 : sec_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen with small divisors.
// Arithmetic model of edge counts drives per-cycle checks.
module tb_tick_gen;

  localparam int FDIV = 4;
  localparam int BDIV = 10;
  localparam int HDIV = 50;
  localparam int SPM  = 3;

  logic clk = 1'b0;
  logic rst_n, run, clear;
  logic en_fast, en_blink, en_2hz, en_1hz, en_1min;
  logic sq_fast, sq_blink, sq_2hz, sq_1hz;
  logic [1:0] sec_cnt;

  int errors = 0;
  int checks = 0;

  // model state: edges since reset, active chain edges since clear/reset
  int k = 0;
  int a = 0;
  bit act = 0;

  tick_gen #(
    .CLK_HZ(100), .FAST_HZ(25), .BLINK_HZ(10), .SEC_PER_MIN(SPM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clear(clear),
    .en_fast(en_fast), .en_blink(en_blink), .en_2hz(en_2hz),
    .en_1hz(en_1hz), .en_1min(en_1min),
    .sq_fast(sq_fast), .sq_blink(sq_blink), .sq_2hz(sq_2hz),
    .sq_1hz(sq_1hz), .sec_cnt(sec_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; a = 0; act = 0;
    end else begin
      k++;
      act = run && !clear;
      if (clear) a = 0;
      else if (run) a++;
    end
  end

  task automatic cmp(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%0d exp=%0d", n, k, got, exp);
    end
  endtask

  always @(negedge clk) begin
    int h, s;
    bit e2, e1;
    h  = a / HDIV;
    s  = h / 2;
    e2 = act && a > 0 && (a % HDIV) == 0;
    e1 = e2 && (h % 2) == 0;
    cmp("en_fast", int'(en_fast), int'(k > 0 && k % FDIV == 0));
    cmp("sq_fast", int'(sq_fast), (k / (FDIV / 2)) % 2);
    cmp("en_blink", int'(en_blink), int'(k > 0 && k % BDIV == 0));
    cmp("sq_blink", int'(sq_blink), (k / (BDIV / 2)) % 2);
    cmp("en_2hz", int'(en_2hz), int'(e2));
    cmp("en_1hz", int'(en_1hz), int'(e1));
    cmp("en_1min", int'(en_1min), int'(e1 && s % SPM == 0));
    cmp("sq_2hz", int'(sq_2hz), h % 2);
    cmp("sq_1hz", int'(sq_1hz), s % 2);
    cmp("sec_cnt", int'(sec_cnt), s % SPM);
  end

  task automatic wait_k(input int n);
    int t = 0;
    while (k != n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (k != n) begin
      checks++;
      errors++;
      $display("FAIL wait_k got=%0d exp=%0d", k, n);
    end
  endtask

  task automatic do_reset(input logic r);
    @(negedge clk);
    #2 rst_n = 1'b0;
    run   = r;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b1;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // free-running run=1
    wait_k(2);   cmp("lit_sq_fast2", int'(sq_fast), 1);
    wait_k(4);   cmp("lit_en_fast4", int'(en_fast), 1);
    wait_k(10);  cmp("lit_en_blink10", int'(en_blink), 1);
    wait_k(50);  cmp("lit_en_2hz50", int'(en_2hz), 1);
                 cmp("lit_en_1hz50", int'(en_1hz), 0);
    wait_k(100); cmp("lit_en_1hz100", int'(en_1hz), 1);
                 cmp("lit_sec100", int'(sec_cnt), 1);
    wait_k(200); cmp("lit_sec200", int'(sec_cnt), 2);
                 cmp("lit_min200", int'(en_1min), 0);
    wait_k(300); cmp("lit_min300", int'(en_1min), 1);
                 cmp("lit_sec300", int'(sec_cnt), 0);
    wait_k(400);

    // pause for 20 edges
    do_reset(1'b1);
    wait_k(120); run = 1'b0;
    wait_k(139); cmp("lit_sec_hold", int'(sec_cnt), 1);
    wait_k(140); run = 1'b1;
    wait_k(200); cmp("lit_en_1hz200_paused", int'(en_1hz), 0);
    wait_k(220); cmp("lit_en_1hz220", int'(en_1hz), 1);
                 cmp("lit_en_fast220", int'(en_fast), 1);
                 cmp("lit_en_blink220", int'(en_blink), 1);

    // clear on the terminal edge
    do_reset(1'b1);
    wait_k(149); cmp("lit_sq1_pre", int'(sq_1hz), 1);
                 clear = 1'b1;
    wait_k(150); clear = 1'b0;
                 cmp("lit_en_2hz150", int'(en_2hz), 0);
                 cmp("lit_sec150", int'(sec_cnt), 0);
                 cmp("lit_sq1_150", int'(sq_1hz), 0);
    wait_k(200); cmp("lit_en_2hz200", int'(en_2hz), 1);
    wait_k(250); cmp("lit_en_1hz250", int'(en_1hz), 1);

    // clear with run low, then resume
    do_reset(1'b1);
    wait_k(60);  clear = 1'b1; run = 1'b0;
    wait_k(62);  clear = 1'b0;
    wait_k(65);  run = 1'b1;
    wait_k(114); cmp("lit_en_2hz114", int'(en_2hz), 0);
    wait_k(115); cmp("lit_en_2hz115", int'(en_2hz), 1);

    // asynchronous reset mid-count
    do_reset(1'b1);
    wait_k(175); cmp("lit_sq_fast175", int'(sq_fast), 1);
                 cmp("lit_sec175", int'(sec_cnt), 1);
    #2 rst_n = 1'b0;
    #1 cmp("lit_async_sq_fast", int'(sq_fast), 0);
       cmp("lit_async_sec", int'(sec_cnt), 0);
       cmp("lit_async_sq_blink", int'(sq_blink), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_k(3);   cmp("lit_en_fast3_rel", int'(en_fast), 0);
    wait_k(4);   cmp("lit_en_fast4_rel", int'(en_fast), 1);
    wait_k(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
# tick_gen

Parametrised timebase for the stopwatch datapath. It divides the board clock into phase-coherent single-cycle enables and 50 %-duty square waves: fast display scan, blink, 2 Hz, 1 Hz and a one-minute enable. The 2 Hz/1 Hz/minute chain can be paused, resumed and cleared. Counter, display-mux and blink logic consume the enables; nothing downstream uses the square waves as clocks.

## Interface
- CLK_HZ, 100_000_000: input clock frequency; must be divisible by 2.
- FAST_HZ, 500: scan enable rate; CLK_HZ must be divisible by 2*FAST_HZ.
- BLINK_HZ, 4: blink enable rate; CLK_HZ must be divisible by 2*BLINK_HZ.
- SEC_PER_MIN, 60: 1 Hz enables per minute enable; must be at least 2.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  1 = seconds chain advances; 0 = chain frozen.
- clear  in  1  synchronous restart of seconds chain; overrides run.
- en_fast, en_blink, en_2hz, en_1hz, en_1min  out  1 each  single-cycle enables.
- sq_fast, sq_blink, sq_2hz, sq_1hz  out  1 each  registered 50 %-duty squares.
- sec_cnt  out  $clog2(SEC_PER_MIN)  seconds within the current minute.

## Operation
- Derived divisors: FAST_DIV = CLK_HZ/FAST_HZ, BLINK_DIV = CLK_HZ/BLINK_HZ, HS_DIV = CLK_HZ/2. Any divisibility violation is an elaboration-time error.
- Fast and blink channels are free-running. They ignore run and clear.
- Each channel counts 0..DIV-1 and wraps to 0.
  - The edge that sees cnt==DIV-1 sets en high for exactly one cycle.
  - sq toggles on the edges that see cnt==DIV/2-1 and cnt==DIV-1.
- Half-second channel (HS_DIV) advances only when run=1. Its en_2hz feeds a phase flag.
  - en_1hz = en_2hz AND phase==1, registered together with en_2hz so both assert in the same cycle.
  - phase toggles on each en_2hz.
  - sq_2hz toggles on each en_2hz; sq_1hz toggles on each en_1hz.
- Seconds counter increments on en_1hz, wrapping SEC_PER_MIN-1 -> 0.
  - en_1min asserts in the same cycle as the en_1hz that performs the wrap.
  - sec_cnt shows the post-increment value in that cycle.
- run=0 holds the half-second count, phase, sq_2hz, sq_1hz and sec_cnt. No chain enables fire. Raising run resumes from the held count with no lost or extra cycles.
- clear=1, registered on the edge, zeros the half-second count, phase, sq_2hz, sq_1hz and sec_cnt. It suppresses chain enables on that edge regardless of run.
- Chain terminal count coinciding with clear: clear wins and no enable fires.

## Timing
- Reset: every counter, flag and output is 0. Reset is asynchronous assert; deassertion is synchronised externally.
- After rst_n rises, the first en_fast is high in the cycle after the FAST_DIV-th rising edge. Subsequent en_fast pulses are exactly FAST_DIV cycles apart. en_blink behaves the same with BLINK_DIV.
- With run held 1 from reset:
  - en_2hz every HS_DIV cycles.
  - en_1hz every 2*HS_DIV cycles, first on the second en_2hz.
  - en_1min every SEC_PER_MIN*CLK_HZ cycles.
- Each run=0 cycle delays all later chain enables by exactly one cycle.
- All outputs are direct register outputs; there is no combinational path from run or clear to any output.
- Reset asserted mid-count zeros everything immediately, and counting restarts from 0 after release.

## Structure
- Shared package/header `tick_pkg`: default CLK_HZ, a clog2 helper and divisor-check macros. No other shared types.
- Sub-module `div_tick`:
  - Parameter DIV.
  - Inputs clk, rst_n, ce, clr.
  - Outputs en, sq.
- tick_gen instantiates div_tick three times:
  - fast: ce=1, clr=0.
  - blink: ce=1, clr=0.
  - half-second: ce=run, clr=clear.
- Phase flag, seconds counter and en_1hz/en_1min registers live in tick_gen.

## Test plan
Every scenario uses CLK_HZ=100, FAST_HZ=25 (DIV 4), BLINK_HZ=10 (DIV 10), SEC_PER_MIN=3 (HS_DIV 50).
- Reset release, run=1 -> en_fast at cycles 4, 8, 12…; sq_fast period 4 cycles at 50 % duty; en_blink at 10, 20…; all outputs 0 during reset.
- run=1 for 400 cycles -> en_2hz at 50, 100, 150…; en_1hz at 100, 200, 300; en_1min only at 300 with sec_cnt 0; sec_cnt sequence 1, 2, 0.
- run=0 for cycles 120-139 -> en_1hz moves from 200 to 220; en_fast and en_blink timing unchanged; sec_cnt holds 1.
- clear pulse at cycle 149 -> en_2hz does not fire at 150; sec_cnt and sq_1hz become 0; next en_2hz at 200 and next en_1hz at 250.
- clear and run=0 together, then run=1 -> chain restarts from 0; first en_2hz 50 cycles after run rises.
- rst_n asserted at cycle 175 for 3 cycles -> all outputs 0 asynchronously; first en_fast 4 cycles after release.
